// File: rtl/uart_tx_fifo.sv
// Byte FIFO in front of the UART transmitter: buffers host writes and launches
// one byte at a time onto the transmitter, paced by its busy flag.
module uart_tx_fifo #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH = 16,
   localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic                  full,
   output logic                  empty,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  overflow,
   output logic                  tx_enable,
   output logic [DATA_WIDTH-1:0] tx_data,
   input  logic                  tx_busy,
   output logic [1:0]            dbg_state
);

   // Handshakes: a host write is taken on any cycle with wr_en high and full low;
   // a write while full is dropped and flagged. Downstream, a byte is launched
   // (tx_enable pulse, tx_data held) only when tx_busy is low, and the next launch
   // waits until tx_busy has been seen to rise and then fall again.

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      LAUNCH    = 2'd1,
      WAIT_BUSY = 2'd2,
      SENDING   = 2'd3
   } state_t;

   localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH+1)'(DEPTH);

   state_t                state;
   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH-1:0] rd_ptr;
   logic                  wr_ok;
   logic                  pop;

   // full/empty come from registered count, so a same-cycle pop never frees a slot.
   assign full      = (count == FULL_COUNT);
   assign empty     = (count == '0);
   assign wr_ok     = wr_en && !full;
   assign pop       = (state == IDLE) && !empty && !tx_busy;
   assign dbg_state = state;

   always_ff @(posedge clk) begin
      if (wr_ok) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (wr_ok) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (wr_en && full) begin
            overflow <= 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({wr_ok, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         tx_enable <= 1'b0;
         tx_data   <= '0;
      end else begin
         tx_enable <= 1'b0;
         case (state)
            IDLE: begin
               if (pop) begin
                  tx_data   <= mem[rd_ptr];
                  tx_enable <= 1'b1;
                  state     <= LAUNCH;
               end
            end
            LAUNCH:    state <= WAIT_BUSY;
            WAIT_BUSY: if (tx_busy) state <= SENDING;
            SENDING:   if (!tx_busy) state <= IDLE;
            default:   state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomized bench for uart_tx_fifo: a queue-based model of the buffer and launch
// pacing, a small transmitter stand-in, and directed scenarios with literal checks.
module tb_uart_tx_fifo;

   localparam int DW    = 8;
   localparam int DEPTH = 16;
   localparam int AW    = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          wr_en;
   logic [DW-1:0] wr_data;
   logic          full;
   logic          empty;
   logic [AW:0]   count;
   logic          overflow;
   logic          tx_enable;
   logic [DW-1:0] tx_data;
   logic          tx_busy;
   logic [1:0]    dbg_state;

   uart_tx_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .reset     (reset),
      .wr_en     (wr_en),
      .wr_data   (wr_data),
      .full      (full),
      .empty     (empty),
      .count     (count),
      .overflow  (overflow),
      .tx_enable (tx_enable),
      .tx_data   (tx_data),
      .tx_busy   (tx_busy),
      .dbg_state (dbg_state)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: run exceeded time limit (actual=timeout required=finish)");
      $fatal(1, "watchdog");
   end

   // ---------------- counters and checker ----------------
   int n_cmp = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
      end
   endfunction

   // ---------------- transmitter stand-in ----------------
   // Auto mode behaves like the UART: busy rises the cycle after a launch
   // pulse and stays high for a random frame length.
   bit            auto_uart = 1'b0;
   logic          man_busy  = 1'b0;
   logic          stub_busy = 1'b0;
   bit            pend      = 1'b0;
   int            busy_cnt  = 0;
   int            n_pulse   = 0;
   logic [DW-1:0] rx_q[$];

   assign tx_busy = auto_uart ? stub_busy : man_busy;

   always @(posedge clk) begin
      #1;
      if (reset) begin
         pend      = 1'b0;
         busy_cnt  = 0;
         stub_busy = 1'b0;
      end else begin
         if (pend) begin
            pend      = 1'b0;
            stub_busy = 1'b1;
            busy_cnt  = $urandom_range(12, 4);
         end else if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) stub_busy = 1'b0;
         end
         if (tx_enable) begin
            rx_q.push_back(tx_data);
            n_pulse++;
            if (auto_uart) pend = 1'b1;
         end
      end
   end

   // ---------------- behavioural model ----------------
   // Queue holds accepted bytes in order. After a launch the sequencer is not
   // free again until one edge has passed, busy was seen high, then seen low.
   logic [DW-1:0] m_q[$];
   bit            m_ovf    = 1'b0;
   logic [DW-1:0] m_data   = '0;
   bit            m_en     = 1'b0;
   int            m_settle = 0;
   bit            m_pop;
   bit            m_full;

   always @(posedge clk) begin
      if (reset) begin
         m_q.delete();
         m_ovf    = 1'b0;
         m_data   = '0;
         m_en     = 1'b0;
         m_settle = 0;
      end else begin
         m_pop  = (m_settle == 0) && (m_q.size() != 0) && !tx_busy;
         m_full = (m_q.size() == DEPTH);
         if (m_settle == 3)                 m_settle = 2;
         else if (m_settle == 2 && tx_busy) m_settle = 1;
         else if (m_settle == 1 && !tx_busy) m_settle = 0;
         m_en = m_pop;
         if (m_pop) begin
            m_data   = m_q.pop_front();
            m_settle = 3;
         end
         if (wr_en) begin
            if (m_full) m_ovf = 1'b1;
            else        m_q.push_back(wr_data);
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (chk_en) begin
         chk("count",     32'(count),     32'(m_q.size()));
         chk("full",      32'(full),      32'(m_q.size() == DEPTH));
         chk("empty",     32'(empty),     32'(m_q.size() == 0));
         chk("overflow",  32'(overflow),  32'(m_ovf));
         chk("tx_enable", 32'(tx_enable), 32'(m_en));
         chk("tx_data",   32'(tx_data),   32'(m_data));
         if (tx_enable) chk("enable_while_busy", 32'(tx_busy), 32'd0);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic write_byte(input logic [DW-1:0] d);
      wr_en   = 1'b1;
      wr_data = d;
      @(negedge clk);
      wr_en   = 1'b0;
   endtask

   task automatic wait_rx(input int n, input int budget, input string tag);
      int c = 0;
      while (rx_q.size() < n && c < budget) begin
         @(negedge clk);
         c++;
      end
      chk(tag, 32'(rx_q.size()), 32'(n));
   endtask

   // ---------------- stimulus ----------------
   logic [DW-1:0] exp_q[$];
   int            p0;
   int            sent;
   int            c;
   logic [DW-1:0] d;

   initial begin
      reset   = 1'b1;
      wr_en   = 1'b0;
      wr_data = '0;
      tick(2);
      chk("rst_count",     32'(count),     32'd0);
      chk("rst_empty",     32'(empty),     32'd1);
      chk("rst_full",      32'(full),      32'd0);
      chk("rst_overflow",  32'(overflow),  32'd0);
      chk("rst_tx_enable", 32'(tx_enable), 32'd0);
      chk("rst_tx_data",   32'(tx_data),   32'd0);
      chk("rst_state",     32'(dbg_state), 32'd0);
      reset  = 1'b0;
      chk_en = 1'b1;
      tick(1);

      // Single byte, busy held low until launch, then high for 40 cycles.
      write_byte(8'hA5);
      chk("single_count1", 32'(count), 32'd1);
      tick(1);
      chk("single_pulse", 32'(tx_enable), 32'd1);
      chk("single_data",  32'(tx_data),   32'hA5);
      chk("single_count0", 32'(count),    32'd0);
      tick(1);
      man_busy = 1'b1;
      p0 = n_pulse;
      tick(40);
      chk("single_no_pulse", 32'(n_pulse - p0), 32'd0);
      chk("single_hold",     32'(tx_data),      32'hA5);
      man_busy = 1'b0;
      tick(3);

      // Burst of three into the transmitter stand-in.
      auto_uart = 1'b1;
      rx_q.delete();
      write_byte(8'h11);
      write_byte(8'h22);
      write_byte(8'h33);
      wait_rx(3, 200, "burst_rx_count");
      chk("burst_rx0", 32'(rx_q[0]), 32'h11);
      chk("burst_rx1", 32'(rx_q[1]), 32'h22);
      chk("burst_rx2", 32'(rx_q[2]), 32'h33);
      tick(20);

      // Fill and overflow with the transmitter held busy.
      auto_uart = 1'b0;
      man_busy  = 1'b1;
      rx_q.delete();
      for (int i = 0; i < 16; i++) write_byte(8'(i));
      chk("fill_full",  32'(full),  32'd1);
      chk("fill_count", 32'(count), 32'd16);
      write_byte(8'h10);
      chk("fill_overflow", 32'(overflow), 32'd1);
      chk("fill_count17",  32'(count),    32'd16);
      auto_uart = 1'b1;
      wait_rx(16, 16 * 30, "fill_rx_count");
      for (int i = 0; i < 16; i++) chk("fill_rx_order", 32'(rx_q[i]), 32'(i));
      tick(30);
      chk("fill_no_extra", 32'(rx_q.size()), 32'd16);

      // Pointer wrap: 40 random bytes in bursts of 7.
      rx_q.delete();
      exp_q.delete();
      sent = 0;
      while (sent < 40) begin
         c = 0;
         while (count > 9 && c < 400) begin
            tick(1);
            c++;
         end
         for (int j = 0; j < 7 && sent < 40; j++) begin
            d = 8'($urandom);
            write_byte(d);
            exp_q.push_back(d);
            sent++;
         end
         tick($urandom_range(30, 0));
      end
      wait_rx(40, 2000, "wrap_rx_count");
      for (int i = 0; i < 40; i++) chk("wrap_rx_order", 32'(rx_q[i]), 32'(exp_q[i]));
      tick(20);
      chk("wrap_empty", 32'(empty), 32'd1);

      // Simultaneous write and pop at count=1.
      auto_uart = 1'b0;
      man_busy  = 1'b1;
      write_byte(8'h5C);
      man_busy = 1'b0;
      write_byte(8'hC3);
      chk("sim_count",  32'(count),     32'd1);
      chk("sim_pulse1", 32'(tx_enable), 32'd1);
      chk("sim_data1",  32'(tx_data),   32'h5C);
      tick(1);
      man_busy = 1'b1;
      tick(5);
      man_busy = 1'b0;
      c = 0;
      while (!tx_enable && c < 10) begin
         tick(1);
         c++;
      end
      chk("sim_pulse2", 32'(tx_enable), 32'd1);
      chk("sim_data2",  32'(tx_data),   32'hC3);
      tick(1);
      man_busy = 1'b1;
      tick(3);
      man_busy = 1'b0;
      tick(3);

      // Reset while a frame is in flight with three bytes queued.
      auto_uart = 1'b1;
      for (int i = 0; i < 4; i++) write_byte(8'($urandom));
      c = 0;
      while (!tx_busy && c < 20) begin
         tick(1);
         c++;
      end
      tick(1);
      chk("mid_count3", 32'(count), 32'd3);
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      chk("mid_count",     32'(count),     32'd0);
      chk("mid_tx_enable", 32'(tx_enable), 32'd0);
      chk("mid_tx_data",   32'(tx_data),   32'd0);
      chk("mid_overflow",  32'(overflow),  32'd0);
      chk("mid_empty",     32'(empty),     32'd1);
      p0 = n_pulse;
      tick(30);
      chk("mid_no_pulse", 32'(n_pulse - p0), 32'd0);
      rx_q.delete();
      write_byte(8'h7E);
      wait_rx(1, 50, "mid_new_rx_count");
      chk("mid_new_rx", 32'(rx_q[0]), 32'h7E);
      tick(20);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
